// File: rtl/uart_frame_loader_pkg.sv
// Shared types and defaults for the UART frame loader.
// Holds frame constants, error codes and FSM encoding.
package uart_frame_loader_pkg;

  localparam int FRAME_BYTES_DEF = 38462;
  localparam int ADDR_W_DEF      = 16;
  localparam int TIMEOUT_DEF     = 2517000;

  localparam logic [7:0] HDR0_DEF = 8'hA5;
  localparam logic [7:0] HDR1_DEF = 8'h5A;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_HDR     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  // Per-cycle actions decoded from state and the incoming byte.
  typedef struct packed {
    logic       wr;
    logic       clr;
    logic       done;
    logic       err;
    logic [1:0] code;
  } act_t;

endpackage

// File: rtl/frame_timeout_ctr.sv
// Saturating idle counter for the frame loader.
// Flags expiry once TIMEOUT_CYC-1 idle clocks have elapsed.
module frame_timeout_ctr #(
  parameter int TIMEOUT_CYC = 2517000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/uart_frame_loader.sv
// Parses header/payload/checksum frames from the UART into
// ping-pong frame RAM banks; swaps banks only on a good frame.
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int         FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic [7:0]        wr_data,
  output logic              disp_bank,
  output logic              frame_ready,
  output logic              frame_done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(FRAME_BYTES - 1);

  state_t            state;
  state_t            state_nxt;
  act_t              act;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        csum;
  logic              expired;
  logic              tmo_clr;
  logic              last_byte;
  logic              csum_ok;

  assign last_byte = (idx == LAST_IDX);
  assign csum_ok   = (rx_data == csum);
  assign tmo_clr   = rx_dv || (state == S_IDLE);
  assign wr_bank   = ~disp_bank;

  frame_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (rx_dv && rx_data == HDR0) begin
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (rx_dv) begin
          if (rx_data == HDR1) begin
            state_nxt = S_PAYLOAD;
          end else if (rx_data != HDR0) begin
            state_nxt = S_IDLE;
          end
        end else if (expired) begin
          state_nxt = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (rx_dv) begin
          if (last_byte) begin
            state_nxt = S_CSUM;
          end
        end else if (expired) begin
          state_nxt = S_IDLE;
        end
      end
      S_CSUM: begin
        if (rx_dv || expired) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    act = '0;
    unique case (state)
      S_IDLE: begin
        act = '0;
      end
      S_HDR: begin
        if (rx_dv) begin
          if (rx_data == HDR1) begin
            act.clr = 1'b1;
          end else if (rx_data != HDR0) begin
            act.err  = 1'b1;
            act.code = ERR_HDR;
          end
        end else if (expired) begin
          act.err  = 1'b1;
          act.code = ERR_TIMEOUT;
        end
      end
      S_PAYLOAD: begin
        if (rx_dv) begin
          act.wr = 1'b1;
        end else if (expired) begin
          act.err  = 1'b1;
          act.code = ERR_TIMEOUT;
        end
      end
      S_CSUM: begin
        if (rx_dv) begin
          if (csum_ok) begin
            act.done = 1'b1;
          end else begin
            act.err  = 1'b1;
            act.code = ERR_CSUM;
          end
        end else if (expired) begin
          act.err  = 1'b1;
          act.code = ERR_TIMEOUT;
        end
      end
      default: act = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      disp_bank   <= 1'b0;
      frame_ready <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      frame_cnt   <= '0;
      idx         <= '0;
      csum        <= '0;
    end else begin
      wr_en      <= act.wr;
      frame_done <= act.done;
      err        <= act.err;
      err_code   <= act.err ? act.code : ERR_NONE;
      if (act.clr) begin
        idx  <= '0;
        csum <= '0;
      end
      if (act.wr) begin
        wr_addr <= idx;
        wr_data <= rx_data;
        idx     <= idx + 1'b1;
        csum    <= csum ^ rx_data;
      end
      if (act.done) begin
        disp_bank   <= ~disp_bank;
        frame_ready <= 1'b1;
        frame_cnt   <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader with 4-byte frames
// and a 50-cycle timeout.
module tb_uart_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic        wr_bank;
  logic [7:0]  wr_data;
  logic        disp_bank;
  logic        frame_ready;
  logic        frame_done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        bank;
  } wr_t;

  typedef struct {
    logic [1:0] code;
    logic       disp;
    logic [7:0] cnt;
    logic       ready;
  } ev_t;

  wr_t wq[$];
  ev_t eq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int byte_cyc = 0;
  int err_cyc = 0;

  logic       m_disp = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic       m_ready = 1'b0;

  uart_frame_loader #(
    .FRAME_BYTES(4),
    .ADDR_W     (16),
    .HDR0       (8'hA5),
    .HDR1       (8'h5A),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_dv      (rx_dv),
    .rx_data    (rx_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_bank    (wr_bank),
    .wr_data    (wr_data),
    .disp_bank  (disp_bank),
    .frame_ready(frame_ready),
    .frame_done (frame_done),
    .err        (err),
    .err_code   (err_code),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          chk("wr_extra", 32'(wr_en), 32'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(w.addr));
          chk("wr_data", 32'(wr_data), 32'(w.data));
          chk("wr_bank", 32'(wr_bank), 32'(w.bank));
        end
      end
      if (frame_done || err) begin
        if (err && err_code == 2'd1) err_cyc = cyc;
        if (eq.size() == 0) begin
          chk("ev_extra", 32'({frame_done, err}), 32'd0);
        end else begin
          ev_t e;
          logic [1:0] code;
          e = eq.pop_front();
          code = frame_done ? 2'd0 : err_code;
          chk("ev_code", 32'(code), 32'(e.code));
          chk("ev_disp", 32'(disp_bank), 32'(e.disp));
          chk("ev_wbank", 32'(wr_bank), 32'(!e.disp));
          chk("ev_cnt", 32'(frame_cnt), 32'(e.cnt));
          chk("ev_ready", 32'(frame_ready), 32'(e.ready));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_dv = 1'b0;
    byte_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0,
                            input logic [7:0] b1,
                            input logic [7:0] b2,
                            input logic [7:0] b3,
                            input bit good);
    logic [7:0] p[4];
    logic [7:0] cs;
    ev_t e;
    p = '{b0, b1, b2, b3};
    cs = b0 ^ b1 ^ b2 ^ b3;
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) begin
      wq.push_back('{addr: 16'(i), data: p[i], bank: !m_disp});
      send_byte(p[i]);
    end
    if (good) begin
      m_disp = !m_disp;
      m_cnt = m_cnt + 8'd1;
      m_ready = 1'b1;
      e = '{code: 2'd0, disp: m_disp, cnt: m_cnt, ready: m_ready};
    end else begin
      e = '{code: 2'd2, disp: m_disp, cnt: m_cnt, ready: m_ready};
    end
    eq.push_back(e);
    send_byte(good ? cs : (cs ^ 8'h01));
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    m_disp = 1'b0;
    m_cnt = 8'd0;
    m_ready = 1'b0;
    #1;
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    @(negedge clk);
    chk({tag, "_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_wbank"}, 32'(wr_bank), 32'd1);
    chk({tag, "_disp"}, 32'(disp_bank), 32'd0);
    chk({tag, "_ready"}, 32'(frame_ready), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"}, 32'({err, err_code}), 32'd0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    ev_t e;
    apply_reset("rst");

    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b1);
    chk("good_ready", 32'(frame_ready), 32'd1);

    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0);

    send_byte(8'h00);
    send_byte(8'hA5);
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 1'b1);

    e = '{code: 2'd3, disp: m_disp, cnt: m_cnt, ready: m_ready};
    eq.push_back(e);
    send_byte(8'hA5);
    send_byte(8'h33);

    send_byte(8'hA5);
    send_byte(8'h5A);
    wq.push_back('{addr: 16'd0, data: 8'h11, bank: !m_disp});
    e = '{code: 2'd1, disp: m_disp, cnt: m_cnt, ready: m_ready};
    eq.push_back(e);
    err_cyc = 0;
    send_byte(8'h11);
    repeat (60) @(negedge clk);
    chk("to_lat", 32'(err_cyc - byte_cyc), 32'd50);
    send_frame(8'hA5, 8'h5A, 8'h00, 8'hFF, 1'b1);

    send_byte(8'hA5);
    send_byte(8'h5A);
    wq.push_back('{addr: 16'd0, data: 8'h77, bank: !m_disp});
    send_byte(8'h77);
    wq.push_back('{addr: 16'd1, data: 8'h88, bank: !m_disp});
    send_byte(8'h88);
    apply_reset("mid");
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

    apply_reset("pp");
    for (int f = 0; f < 257; f++) begin
      send_frame(8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 1'b1);
    end
    repeat (4) @(negedge clk);
    chk("cnt_wrap", 32'(frame_cnt), 32'd1);
    chk("disp_end", 32'(disp_bank), 32'd1);
    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("eq_left", 32'(eq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
